// File: rtl/blink_meter_pkg.sv
// Shared types and defaults for the LED pin measurement block.
// Bench and RTL both take the state encoding from here.
package blink_meter_pkg;

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2
    } meter_state_e;

    localparam int DEF_CNT_W       = 24;
    localparam int DEF_TIMEOUT_CYC = 1_000_000;
    localparam int DEF_EDGE_W      = 16;

endpackage

// File: rtl/pin_sync.sv
// Multi-flop synchroniser for asynchronous pad inputs.
// DEPTH must be at least 2.
module pin_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sync_q;
    logic [DEPTH-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[DEPTH-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/blink_meter.sv
// Measures high, low and period of an asynchronous LED pin in clk cycles,
// counts rising edges and flags a pin that has stopped toggling.
module blink_meter
    import blink_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int EDGE_W      = DEF_EDGE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              ledpin,
    output logic [CNT_W-1:0]  hi_len,
    output logic [CNT_W-1:0]  lo_len,
    output logic [CNT_W-1:0]  period,
    output logic              meas_valid,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic              stuck
);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    logic s;
    logic s_d_q, s_d_d;
    logic rise, fall, edge_any;

    meter_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  hi_len_q, hi_len_d;
    logic [CNT_W-1:0]  lo_len_q, lo_len_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              meas_valid_q, meas_valid_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic              stuck_q, stuck_d;
    logic              hi_seen_q, hi_seen_d;
    logic [CNT_W:0]    sum;

    pin_sync #(.DEPTH(2)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ledpin),
        .q     (s)
    );

    assign rise     = s & ~s_d_q;
    assign fall     = ~s & s_d_q;
    assign edge_any = rise | fall;
    assign sum      = {1'b0, hi_len_q} + {1'b0, cnt_q};

    always_comb begin
        s_d_d        = s;
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_len_d     = hi_len_q;
        lo_len_d     = lo_len_q;
        period_d     = period_q;
        meas_valid_d = 1'b0;
        edge_cnt_d   = edge_cnt_q;
        stuck_d      = stuck_q;
        hi_seen_d    = hi_seen_q;

        // The edge cycle is the first cycle of the new level.
        if (edge_any) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (edge_any) begin
            stuck_d = 1'b0;
        end else if (cnt_d == TIMEOUT_VAL) begin
            stuck_d = 1'b1;
        end

        unique case (state_q)
            WAIT_EDGE: begin
                if (rise) begin
                    state_d    = HIGH;
                    edge_cnt_d = edge_cnt_q + EDGE_W'(1);
                end else if (fall) begin
                    state_d = LOW;
                end
            end
            HIGH: begin
                if (fall) begin
                    hi_len_d  = cnt_q;
                    hi_seen_d = 1'b1;
                    state_d   = LOW;
                end
            end
            LOW: begin
                if (rise) begin
                    lo_len_d   = cnt_q;
                    edge_cnt_d = edge_cnt_q + EDGE_W'(1);
                    state_d    = HIGH;
                    if (hi_seen_q) begin
                        period_d     = sum[CNT_W] ? CNT_MAX
                                                  : sum[CNT_W-1:0];
                        meas_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = WAIT_EDGE;
        endcase

        // Clear overrides any edge seen in the same cycle.
        if (clr) begin
            state_d      = WAIT_EDGE;
            cnt_d        = '0;
            hi_len_d     = '0;
            lo_len_d     = '0;
            period_d     = '0;
            meas_valid_d = 1'b0;
            edge_cnt_d   = '0;
            stuck_d      = 1'b0;
            hi_seen_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d_q        <= 1'b0;
            state_q      <= WAIT_EDGE;
            cnt_q        <= '0;
            hi_len_q     <= '0;
            lo_len_q     <= '0;
            period_q     <= '0;
            meas_valid_q <= 1'b0;
            edge_cnt_q   <= '0;
            stuck_q      <= 1'b0;
            hi_seen_q    <= 1'b0;
        end else begin
            s_d_q        <= s_d_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_len_q     <= hi_len_d;
            lo_len_q     <= lo_len_d;
            period_q     <= period_d;
            meas_valid_q <= meas_valid_d;
            edge_cnt_q   <= edge_cnt_d;
            stuck_q      <= stuck_d;
            hi_seen_q    <= hi_seen_d;
        end
    end

    assign hi_len     = hi_len_q;
    assign lo_len     = lo_len_q;
    assign period     = period_q;
    assign meas_valid = meas_valid_q;
    assign edge_cnt   = edge_cnt_q;
    assign stuck      = stuck_q;

endmodule
